// File: rtl/sprite_row_fetch.sv
// Fetches one sprite row of BYTES_PER_ROW ROM bytes into the line buffer.
// Optionally mirrors the row horizontally (byte order reversed, pixel bits flipped).
module sprite_row_fetch #(
   parameter int BYTES_PER_ROW = 4,
   parameter int ADDR_W        = 12,
   parameter int ROW_W         = 5,
   parameter int IDX_W         = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ROW_W-1:0]  row,
   input  logic              mirror,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              buf_we,
   output logic [IDX_W-1:0]  buf_addr,
   output logic [7:0]        buf_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_ROW - 1);

   state_t            state_reg;
   state_t            state_next;
   logic [IDX_W-1:0]  idx_reg;
   logic              drain_reg;
   logic [ADDR_W-1:0] row_base_reg;
   logic              mirror_reg;
   logic              rd_valid_reg;
   logic [IDX_W-1:0]  rd_idx_reg;

   logic [ADDR_W-1:0] start_addr;
   logic              fetch_last;
   logic [7:0]        flipped;

   // Row start address; the sum wraps naturally at ADDR_W bits.
   assign start_addr = base_addr + ADDR_W'(row) * ADDR_W'(BYTES_PER_ROW);
   assign fetch_last = (idx_reg == LAST_IDX);

   assign flipped[7] = rom_data[7];
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_flip
         assign flipped[gi] = rom_data[6-gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = FETCH;
         FETCH:   if (fetch_last) state_next = DRAIN;
         DRAIN:   if (drain_reg) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         FETCH:   busy = 1'b1;
         DRAIN:   busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Address sequencing: the address for byte i+1 is registered while byte i is on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg      <= '0;
         drain_reg    <= 1'b0;
         row_base_reg <= '0;
         mirror_reg   <= 1'b0;
         rom_addr     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  row_base_reg <= start_addr;
                  rom_addr     <= start_addr;
                  mirror_reg   <= mirror;
                  idx_reg      <= '0;
               end
            end
            FETCH: begin
               drain_reg <= 1'b0;
               if (!fetch_last) begin
                  idx_reg  <= idx_reg + 1'b1;
                  rom_addr <= row_base_reg + ADDR_W'(idx_reg) + ADDR_W'(1);
               end
            end
            DRAIN:   drain_reg <= 1'b1;
            default: ;
         endcase
      end
   end

   // Write pipeline: rd_valid marks the cycle in which rom_data holds a requested byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_reg <= 1'b0;
         rd_idx_reg   <= '0;
         buf_we       <= 1'b0;
         buf_addr     <= '0;
         buf_data     <= '0;
      end else begin
         rd_valid_reg <= (state_reg == FETCH);
         rd_idx_reg   <= idx_reg;
         buf_we       <= rd_valid_reg;
         if (rd_valid_reg) begin
            buf_addr <= mirror_reg ? (LAST_IDX - rd_idx_reg) : rd_idx_reg;
            buf_data <= mirror_reg ? flipped : rom_data;
         end
      end
   end

endmodule

// File: tb/tb_sprite_row_fetch.sv
// Bench for sprite_row_fetch: two instances (4 bytes/row and 1 byte/row) checked
// cycle by cycle against a list of expected addresses and writes built from a ROM model.
module tb_sprite_row_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   logic [11:0] base_addr = '0;
   logic [4:0]  row = '0;
   logic        mirror = 1'b0;

   logic        start4, start1;
   logic [11:0] rom_addr4, rom_addr1;
   logic [7:0]  rom_data4, rom_data1;
   logic        buf_we4, buf_we1;
   logic [1:0]  buf_addr4;
   logic [0:0]  buf_addr1;
   logic [7:0]  buf_data4, buf_data1;
   logic        busy4, busy1, done4, done1;

   assign start4 = start & ~sel;
   assign start1 = start & sel;

   sprite_row_fetch #(.BYTES_PER_ROW(4), .ADDR_W(12), .ROW_W(5), .IDX_W(2)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .base_addr(base_addr), .row(row),
      .mirror(mirror), .rom_addr(rom_addr4), .rom_data(rom_data4), .buf_we(buf_we4),
      .buf_addr(buf_addr4), .buf_data(buf_data4), .busy(busy4), .done(done4));

   sprite_row_fetch #(.BYTES_PER_ROW(1), .ADDR_W(12), .ROW_W(5), .IDX_W(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .base_addr(base_addr), .row(row),
      .mirror(mirror), .rom_addr(rom_addr1), .rom_data(rom_data1), .buf_we(buf_we1),
      .buf_addr(buf_addr1), .buf_data(buf_data1), .busy(busy1), .done(done1));

   logic [7:0] rom [0:4095];
   always @(posedge clk) begin
      rom_data4 <= rom[rom_addr4];
      rom_data1 <= rom[rom_addr1];
   end

   logic [11:0] o_raddr;
   logic        o_we, o_busy, o_done;
   logic [1:0]  o_baddr;
   logic [7:0]  o_bdata;
   assign o_raddr = sel ? rom_addr1 : rom_addr4;
   assign o_we    = sel ? buf_we1 : buf_we4;
   assign o_busy  = sel ? busy1 : busy4;
   assign o_done  = sel ? done1 : done4;
   assign o_baddr = sel ? {1'b0, buf_addr1} : buf_addr4;
   assign o_bdata = sel ? buf_data1 : buf_data4;

   int total = 0;
   int bad = 0;
   logic [11:0] last_addr4 = '0;
   logic [11:0] last_addr1 = '0;

   function automatic logic [7:0] flip(input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      r[7] = b[7];
      for (int k = 0; k < 7; k++) r[k] = b[6-k];
      return r;
   endfunction

   task automatic run_fetch(input int n, input logic [11:0] b, input logic [4:0] r,
                            input logic m, input int ign_a, input int ign_b, input string tag);
      logic [11:0] e_addr [4];
      logic [1:0]  e_idx [4];
      logic [7:0]  e_dat [4];
      logic [11:0] want_addr;
      logic        want;
      int          a;
      for (int i = 0; i < n; i++) begin
         a = (int'(b) + int'(r) * n + i) % 4096;
         e_addr[i] = 12'(a);
         e_idx[i]  = m ? 2'(n - 1 - i) : 2'(i);
         e_dat[i]  = m ? flip(rom[a]) : rom[a];
      end
      sel = (n == 1);
      for (int c = 0; c <= n + 3; c++) begin
         start = (c == 0) || (c == ign_a) || (c == ign_b);
         if (c == 0) begin
            base_addr = b; row = r; mirror = m;
         end else begin
            base_addr = 12'($urandom); row = 5'($urandom); mirror = 1'($urandom);
         end
         @(negedge clk);
         want = (c >= 1 && c <= n + 3);
         total++;
         if (o_busy !== want) begin
            bad++; $display("FAIL %s c%0d busy got=%b want=%b", tag, c, o_busy, want);
         end
         want = (c == n + 3);
         total++;
         if (o_done !== want) begin
            bad++; $display("FAIL %s c%0d done got=%b want=%b", tag, c, o_done, want);
         end
         want = (c >= 3 && c <= n + 2);
         total++;
         if (o_we !== want) begin
            bad++; $display("FAIL %s c%0d buf_we got=%b want=%b", tag, c, o_we, want);
         end
         if (c >= 3 && c <= n + 2) begin
            total++;
            if (o_baddr !== e_idx[c-3]) begin
               bad++; $display("FAIL %s c%0d buf_addr got=%0d want=%0d", tag, c, o_baddr, e_idx[c-3]);
            end
            total++;
            if (o_bdata !== e_dat[c-3]) begin
               bad++; $display("FAIL %s c%0d buf_data got=%h want=%h", tag, c, o_bdata, e_dat[c-3]);
            end
         end
         if (c == 0) want_addr = sel ? last_addr1 : last_addr4;
         else if (c <= n) want_addr = e_addr[c-1];
         else want_addr = e_addr[n-1];
         total++;
         if (o_raddr !== want_addr) begin
            bad++; $display("FAIL %s c%0d rom_addr got=%h want=%h", tag, c, o_raddr, want_addr);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (sel) last_addr1 = e_addr[n-1]; else last_addr4 = e_addr[n-1];
      $display("%s: n=%0d base=%h row=%0d mirror=%b ignored_starts=%0d,%0d", tag, n, b, r, m, ign_a, ign_b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if ({busy4, done4, buf_we4, busy1, done1, buf_we1} !== 6'b0) begin
         bad++; $display("FAIL reset flags got=%b want=000000", {busy4, done4, buf_we4, busy1, done1, buf_we1});
      end
      total++;
      if ({rom_addr4, rom_addr1, buf_addr4, buf_addr1, buf_data4, buf_data1} !== '0) begin
         bad++; $display("FAIL reset data got=%h/%h/%h/%h want=0", rom_addr4, rom_addr1, buf_data4, buf_data1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      last_addr4 = '0;
      last_addr1 = '0;
      $display("reset: outputs checked");
   endtask

   task automatic test_basic();
      rom[12'h108] = 8'h81; rom[12'h109] = 8'h02; rom[12'h10A] = 8'h40; rom[12'h10B] = 8'h7F;
      run_fetch(4, 12'h100, 5'd2, 1'b0, -1, -1, "T1 plain");
      run_fetch(4, 12'h100, 5'd2, 1'b1, -1, -1, "T2 mirror");
   endtask

   task automatic test_wrap();
      run_fetch(4, 12'hFFE, 5'd0, 1'b0, -1, -1, "T3 wrap");
      run_fetch(4, 12'hFF0, 5'd31, 1'b1, -1, -1, "T3 wrap row");
   endtask

   task automatic test_back_to_back();
      run_fetch(4, 12'h2A0, 5'd5, 1'b0, 2, 7, "T4 ignored starts");
      run_fetch(4, 12'h2A0, 5'd6, 1'b1, -1, -1, "T4 accepted in idle");
   endtask

   task automatic test_midfetch_reset();
      sel = 1'b0;
      base_addr = 12'h300; row = 5'd1; mirror = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 4; c <= 9; c++) begin
         @(negedge clk);
         total++;
         if ({busy4, buf_we4, done4} !== 3'b000) begin
            bad++; $display("FAIL T5 c%0d busy/we/done got=%b want=000", c, {busy4, buf_we4, done4});
         end
         total++;
         if (rom_addr4 !== 12'h000) begin
            bad++; $display("FAIL T5 c%0d rom_addr got=%h want=000", c, rom_addr4);
         end
         @(posedge clk); #1;
      end
      last_addr4 = '0;
      last_addr1 = '0;
      $display("T5 reset mid-fetch: quiet afterwards");
      run_fetch(4, 12'h300, 5'd1, 1'b0, -1, -1, "T5 fresh start");
   endtask

   task automatic test_single_byte();
      run_fetch(1, 12'h050, 5'd3, 1'b0, -1, -1, "T6 n=1");
      run_fetch(1, 12'hFFF, 5'd0, 1'b1, 2, 4, "T6 n=1 mirror");
   endtask

   task automatic test_random();
      int n;
      for (int t = 0; t < 16; t++) begin
         n = ($urandom_range(0, 3) == 0) ? 1 : 4;
         run_fetch(n, 12'($urandom), 5'($urandom), 1'($urandom),
                   int'($urandom_range(1, n + 3)), int'($urandom_range(1, n + 3)), "random");
      end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_midfetch_reset();
      test_single_byte();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
